// File: rtl/lfsr_prbs_generator.sv
// rtl/lfsr_prbs_generator.sv - Fibonacci LFSR PRBS generator with MSB-first word packing and backpressure
//
// Ports:
//   clock       sole clock, rising edge
//   rst         asynchronous active-high reset
//   seed        value captured into the LFSR (and the wrap reference) on load
//   load        seed load strobe; wins over enable
//   taps        feedback tap mask captured on taps_load
//   taps_load   tap mask load strobe
//   enable      request one LFSR shift this cycle
//   out_ready   consumer accepts the current word this cycle
//   q           serial bit, state MSB
//   data        packed output word, first bit in the MSB
//   data_valid  data holds a complete word
//   state       current LFSR state
//   wrapped     one-cycle pulse after a shift lands on the last loaded seed
//   cfg_err     one-cycle pulse on zero seed, zero taps, or zero-state guard
module lfsr_prbs_generator #(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       OUT_BITS     = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_TAPS = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(1)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [WIDTH-1:0]    seed,
  input  logic                load,
  input  logic [WIDTH-1:0]    taps,
  input  logic                taps_load,
  input  logic                enable,
  input  logic                out_ready,
  output logic                q,
  output logic [OUT_BITS-1:0] data,
  output logic                data_valid,
  output logic [WIDTH-1:0]    state,
  output logic                wrapped,
  output logic                cfg_err
);

  // Bit counter runs 0..OUT_BITS-1; a single-bit word still needs a 1-bit counter.
  localparam int unsigned      CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_BITS - 1);

  logic [WIDTH-1:0]    state_r;
  logic [WIDTH-1:0]    seed_reg;
  logic [WIDTH-1:0]    tap_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [OUT_BITS-1:0] word_buf;
  logic [OUT_BITS-1:0] data_r;
  logic                data_valid_r;
  logic                wrapped_r;
  logic                cfg_err_r;

  logic                stall;
  logic                do_shift;
  logic                fb;
  logic [WIDTH-1:0]    shifted;
  logic                shift_zero;
  logic [WIDTH-1:0]    shift_next;
  logic [OUT_BITS-1:0] buf_next;
  logic                word_done;
  logic                seed_zero;
  logic                taps_zero;
  logic [WIDTH-1:0]    load_value;

  always_comb begin
    stall      = data_valid_r & ~out_ready;
    do_shift   = enable & ~load & ~stall;

    fb         = ^(state_r & tap_reg);
    shifted    = {state_r[WIDTH-2:0], fb};
    // A stuck-at-zero LFSR would never recover, so zero is replaced by the default seed.
    shift_zero = (shifted == '0);
    shift_next = shift_zero ? DEFAULT_SEED : shifted;

    // The outgoing bit is the pre-shift MSB; shifting in at the LSB leaves the
    // first bit of the word in the MSB once OUT_BITS bits have arrived.
    buf_next   = (word_buf << 1) | OUT_BITS'(state_r[WIDTH-1]);
    word_done  = do_shift & (bit_cnt == LAST_BIT);

    seed_zero  = (seed == '0);
    taps_zero  = (taps == '0);
    load_value = seed_zero ? DEFAULT_SEED : seed;
  end

  // Tap mask: a zero mask is rejected and the previous mask kept.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tap_reg <= DEFAULT_TAPS;
    end else if (taps_load && !taps_zero) begin
      tap_reg <= taps;
    end
  end

  // LFSR state and the wrap reference seed.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r  <= DEFAULT_SEED;
      seed_reg <= DEFAULT_SEED;
    end else if (load) begin
      state_r  <= load_value;
      seed_reg <= load_value;
    end else if (do_shift) begin
      state_r  <= shift_next;
    end
  end

  // Word assembly and output handshake.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      word_buf     <= '0;
      data_r       <= '0;
      data_valid_r <= 1'b0;
    end else if (load) begin
      bit_cnt      <= '0;
      word_buf     <= '0;
      data_valid_r <= 1'b0;
    end else begin
      // Consumption first; a word completing on the same edge overrides it.
      if (data_valid_r && out_ready) begin
        data_valid_r <= 1'b0;
      end
      if (do_shift) begin
        if (word_done) begin
          data_r       <= buf_next;
          data_valid_r <= 1'b1;
          bit_cnt      <= '0;
          word_buf     <= '0;
        end else begin
          word_buf     <= buf_next;
          bit_cnt      <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Single-cycle status pulses. All error sources share one register so
  // simultaneous errors still produce one pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wrapped_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      wrapped_r <= do_shift & (shift_next == seed_reg);
      cfg_err_r <= (load & seed_zero) | (taps_load & taps_zero) | (do_shift & shift_zero);
    end
  end

  assign q          = state_r[WIDTH-1];
  assign state      = state_r;
  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign wrapped    = wrapped_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_lfsr_prbs_generator.sv
// tb/tb_lfsr_prbs_generator.sv - randomized and directed bench for lfsr_prbs_generator
module tb_lfsr_prbs_generator;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic rst;

  // Instance A: 4-bit LFSR, 4-bit words
  logic [3:0] a_seed, a_taps, a_data, a_state;
  logic       a_load, a_taps_load, a_enable, a_out_ready;
  logic       a_q, a_data_valid, a_wrapped, a_cfg_err;

  // Instance B: default parameters
  logic [31:0] b_seed, b_taps, b_state;
  logic [7:0]  b_data;
  logic        b_load, b_taps_load, b_enable, b_out_ready;
  logic        b_q, b_data_valid, b_wrapped, b_cfg_err;

  lfsr_prbs_generator #(
    .WIDTH(4), .OUT_BITS(4), .DEFAULT_TAPS(4'b1001), .DEFAULT_SEED(4'b0001)
  ) dut_a (
    .clock(clock), .rst(rst), .seed(a_seed), .load(a_load), .taps(a_taps),
    .taps_load(a_taps_load), .enable(a_enable), .out_ready(a_out_ready),
    .q(a_q), .data(a_data), .data_valid(a_data_valid), .state(a_state),
    .wrapped(a_wrapped), .cfg_err(a_cfg_err)
  );

  lfsr_prbs_generator dut_b (
    .clock(clock), .rst(rst), .seed(b_seed), .load(b_load), .taps(b_taps),
    .taps_load(b_taps_load), .enable(b_enable), .out_ready(b_out_ready),
    .q(b_q), .data(b_data), .data_valid(b_data_valid), .state(b_state),
    .wrapped(b_wrapped), .cfg_err(b_cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = A, 1 = B
  int          mw      [2] = '{4, 32};
  int          mob     [2] = '{4, 8};
  logic [63:0] m_dseed [2] = '{64'd1, 64'd1};
  logic [63:0] m_dtaps [2] = '{64'h9, 64'h8020_0003};
  logic [63:0] m_state [2];
  logic [63:0] m_seedr [2];
  logic [63:0] m_taps  [2];
  logic [63:0] m_data  [2];
  logic [63:0] m_word  [2];
  int          m_cnt   [2];
  logic        m_valid [2];
  logic        m_wrap  [2];
  logic        m_err   [2];

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = m_dseed[i]; m_seedr[i] = m_dseed[i]; m_taps[i] = m_dtaps[i];
      m_data[i] = '0; m_word[i] = '0; m_cnt[i] = 0;
      m_valid[i] = 1'b0; m_wrap[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int id, input logic ld, input logic [63:0] sd,
                            input logic tl, input logic [63:0] tp,
                            input logic en, input logic rdy);
    logic [63:0] ns;
    logic        fb, go, err;
    int          w;
    w   = mw[id];
    go  = en && !ld && !(m_valid[id] && !rdy);
    err = 1'b0;
    m_wrap[id] = 1'b0;
    if (m_valid[id] && rdy) m_valid[id] = 1'b0;
    if (go) begin
      fb = 1'b0;
      for (int i = 0; i < w; i++) if (m_taps[id][i]) fb = fb ^ m_state[id][i];
      m_word[id] = {m_word[id][62:0], m_state[id][w-1]};
      m_cnt[id]  = m_cnt[id] + 1;
      if (m_cnt[id] == mob[id]) begin
        m_data[id] = m_word[id]; m_valid[id] = 1'b1; m_word[id] = '0; m_cnt[id] = 0;
      end
      ns = {m_state[id][62:0], fb} & mask_of(w);
      if (ns == '0) begin ns = m_dseed[id]; err = 1'b1; end
      m_state[id] = ns;
      m_wrap[id]  = (ns == m_seedr[id]);
    end
    if (ld) begin
      if (sd == '0) begin m_state[id] = m_dseed[id]; err = 1'b1; end
      else m_state[id] = sd;
      m_seedr[id] = m_state[id];
      m_word[id] = '0; m_cnt[id] = 0; m_valid[id] = 1'b0;
    end
    if (tl) begin
      if (tp == '0) err = 1'b1;
      else m_taps[id] = tp;
    end
    m_err[id] = err;
  endtask

  task automatic tick();
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, a_load, {60'b0, a_seed}, a_taps_load, {60'b0, a_taps}, a_enable, a_out_ready);
      model_step(1, b_load, {32'b0, b_seed}, b_taps_load, {32'b0, b_taps}, b_enable, b_out_ready);
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_load = 1'b0; a_taps_load = 1'b0; a_enable = 1'b0; a_out_ready = 1'b1;
    b_load = 1'b0; b_taps_load = 1'b0; b_enable = 1'b0; b_out_ready = 1'b1;
  endtask

  function automatic logic [11:0] exp_a();
    return {m_state[0][3:0], m_data[0][3:0], m_valid[0], m_wrap[0], m_err[0], m_state[0][3]};
  endfunction

  function automatic logic [43:0] exp_b();
    return {m_state[1][31:0], m_data[1][7:0], m_valid[1], m_wrap[1], m_err[1], m_state[1][31]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    a_seed = '0; a_taps = '0; b_seed = '0; b_taps = '0;
    model_reset();
    #3;
    n_checks++; if (a_state !== 4'b0001) begin n_fail++; $display("FAIL reset_a_state: got %b want 0001", a_state); end
    n_checks++; if (b_state !== 32'h1) begin n_fail++; $display("FAIL reset_b_state: got %h want 00000001", b_state); end
    n_checks++; if ({a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== 8'b0) begin n_fail++; $display("FAIL reset_a_outs: got %b want 00000000", {a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}); end
    n_checks++; if ({b_data, b_data_valid, b_wrapped, b_cfg_err, b_q} !== 12'b0) begin n_fail++; $display("FAIL reset_b_outs: got %b want 0", {b_data, b_data_valid, b_wrapped, b_cfg_err, b_q}); end
    tick(); tick();
    n_checks++; if (b_state !== 32'h1 || b_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held: state %h valid %b want 00000001 0", b_state, b_data_valid); end
    rst = 1'b0;
    tick();
    n_checks++; if ({a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== exp_a()) begin n_fail++; $display("FAIL reset_release_a: got %b want %b", {a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}, exp_a()); end
  endtask

  task automatic test_seq4();
    logic [3:0] exp_st [4] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011};
    logic       exp_q  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       pre_q;
    int         wraps, wrap_at;
    a_taps = 4'b1100; a_taps_load = 1'b1; a_seed = 4'b0001; a_load = 1'b1;
    tick();
    a_taps_load = 1'b0; a_load = 1'b0;
    n_checks++; if (a_state !== 4'b0001 || a_cfg_err !== 1'b0) begin n_fail++; $display("FAIL seq4_load: state %b err %b want 0001 0", a_state, a_cfg_err); end
    a_enable = 1'b1; a_out_ready = 1'b1;
    wraps = 0; wrap_at = -1;
    for (int i = 1; i <= 16; i++) begin
      pre_q = a_q;
      tick();
      if (i <= 4) begin
        n_checks++; if (a_state !== exp_st[i-1] || pre_q !== exp_q[i-1]) begin n_fail++; $display("FAIL seq4_step%0d: state %b q %b want %b %b", i, a_state, pre_q, exp_st[i-1], exp_q[i-1]); end
      end
      if (i == 4) begin
        n_checks++; if (a_data_valid !== 1'b1 || a_data !== 4'b0001) begin n_fail++; $display("FAIL seq4_word: valid %b data %b want 1 0001", a_data_valid, a_data); end
      end
      n_checks++; if ({a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== exp_a()) begin n_fail++; $display("FAIL seq4_model%0d: got %b want %b", i, {a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}, exp_a()); end
      if (a_wrapped === 1'b1) begin wraps++; wrap_at = i; end
    end
    n_checks++; if (wraps != 1 || wrap_at != 15) begin n_fail++; $display("FAIL seq4_wrap: count %0d at %0d want 1 at 15", wraps, wrap_at); end
    a_enable = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    a_seed = 4'b0001; a_load = 1'b1; a_enable = 1'b1; a_out_ready = 1'b0;
    tick();
    a_load = 1'b0;
    n_checks++; if (a_state !== 4'b0001) begin n_fail++; $display("FAIL stall_load_wins: state %b want 0001", a_state); end
    repeat (4) tick();
    n_checks++; if (a_data_valid !== 1'b1 || a_data !== 4'b0001 || a_state !== 4'b0011) begin n_fail++; $display("FAIL stall_word: valid %b data %b state %b want 1 0001 0011", a_data_valid, a_data, a_state); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (a_state !== 4'b0011 || a_data_valid !== 1'b1 || a_data !== 4'b0001) begin n_fail++; $display("FAIL stall_hold%0d: state %b valid %b data %b want 0011 1 0001", i, a_state, a_data_valid, a_data); end
    end
    a_out_ready = 1'b1;
    tick();
    n_checks++; if (a_state !== 4'b0110 || a_data_valid !== 1'b0) begin n_fail++; $display("FAIL stall_resume: state %b valid %b want 0110 0", a_state, a_data_valid); end
    a_enable = 1'b0;
    tick();
  endtask

  task automatic test_zero_guard();
    a_taps = 4'b0100; a_taps_load = 1'b1; a_seed = 4'b1000; a_load = 1'b1;
    tick();
    a_taps_load = 1'b0; a_load = 1'b0; a_enable = 1'b1;
    tick();
    a_enable = 1'b0;
    n_checks++; if (a_state !== 4'b0001 || a_cfg_err !== 1'b1) begin n_fail++; $display("FAIL zero_guard: state %b err %b want 0001 1", a_state, a_cfg_err); end
    tick();
    n_checks++; if (a_cfg_err !== 1'b0) begin n_fail++; $display("FAIL zero_guard_pulse: err %b want 0", a_cfg_err); end
  endtask

  task automatic test_defaults();
    int pulses [$];
    b_seed = 32'h150F_2464; b_load = 1'b1;
    tick();
    b_load = 1'b0; b_enable = 1'b1; b_out_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_checks++; if ({b_state, b_data, b_data_valid, b_wrapped, b_cfg_err, b_q} !== exp_b()) begin n_fail++; $display("FAIL defaults_cyc%0d: got %h want %h", i, {b_state, b_data, b_data_valid, b_wrapped, b_cfg_err, b_q}, exp_b()); end
      if (b_data_valid === 1'b1) pulses.push_back(i);
    end
    b_enable = 1'b0;
    n_checks++; if (pulses.size() != 5) begin n_fail++; $display("FAIL defaults_words: got %0d want 5", pulses.size()); end
    for (int k = 0; k < pulses.size(); k++) begin
      n_checks++; if (pulses[k] != 8 * (k + 1)) begin n_fail++; $display("FAIL defaults_spacing%0d: got cycle %0d want %0d", k, pulses[k], 8 * (k + 1)); end
    end
    tick();
  endtask

  task automatic test_cfg_err();
    b_seed = 32'h0; b_load = 1'b1;
    tick();
    b_load = 1'b0;
    n_checks++; if (b_state !== 32'h1 || b_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_zero_seed: state %h err %b want 00000001 1", b_state, b_cfg_err); end
    tick();
    n_checks++; if (b_cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_seed_pulse: err %b want 0", b_cfg_err); end
    b_taps = 32'h0; b_taps_load = 1'b1;
    tick();
    b_taps_load = 1'b0;
    n_checks++; if (b_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_zero_taps: err %b want 1", b_cfg_err); end
    b_enable = 1'b1;
    tick();
    n_checks++; if (b_cfg_err !== 1'b0 || b_state !== 32'h3) begin n_fail++; $display("FAIL cfg_taps_kept1: err %b state %h want 0 00000003", b_cfg_err, b_state); end
    tick();
    b_enable = 1'b0;
    n_checks++; if (b_state !== 32'h6) begin n_fail++; $display("FAIL cfg_taps_kept2: state %h want 00000006", b_state); end
    b_load = 1'b1; b_taps_load = 1'b1;
    tick();
    b_load = 1'b0; b_taps_load = 1'b0;
    n_checks++; if (b_cfg_err !== 1'b1 || b_state !== 32'h1) begin n_fail++; $display("FAIL cfg_both: err %b state %h want 1 00000001", b_cfg_err, b_state); end
    tick();
    n_checks++; if (b_cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_both_single: err %b want 0", b_cfg_err); end
  endtask

  task automatic test_load_midword();
    logic [31:0] s1, s2;
    s1 = $urandom; if (s1 == 32'h0) s1 = 32'h1;
    s2 = $urandom; if (s2 == 32'h0) s2 = 32'h2;
    b_seed = s1; b_load = 1'b1;
    tick();
    b_load = 1'b0; b_enable = 1'b1; b_out_ready = 1'b1;
    repeat (11) tick();
    b_seed = s2; b_load = 1'b1;
    tick();
    b_load = 1'b0;
    n_checks++; if (b_state !== s2 || b_data_valid !== 1'b0) begin n_fail++; $display("FAIL midword_load: state %h valid %b want %h 0", b_state, b_data_valid, s2); end
    b_out_ready = 1'b0;
    repeat (8) tick();
    n_checks++; if (b_data_valid !== 1'b1) begin n_fail++; $display("FAIL midword_pending: valid %b want 1", b_data_valid); end
    b_seed = s1; b_load = 1'b1;
    tick();
    b_load = 1'b0; b_out_ready = 1'b1;
    n_checks++; if (b_state !== s1 || b_data_valid !== 1'b0) begin n_fail++; $display("FAIL midword_drop: state %h valid %b want %h 0", b_state, b_data_valid, s1); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        n_checks++; if (b_data_valid !== 1'b0) begin n_fail++; $display("FAIL midword_early%0d: valid %b want 0", i, b_data_valid); end
      end
    end
    b_enable = 1'b0;
    n_checks++; if (b_data_valid !== 1'b1 || b_data !== s1[31:24]) begin n_fail++; $display("FAIL midword_word: valid %b data %h want 1 %h", b_data_valid, b_data, s1[31:24]); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_load      = ($urandom_range(0, 19) == 0);
      a_seed      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      a_taps_load = ($urandom_range(0, 14) == 0);
      a_taps      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      a_enable    = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_load      = ($urandom_range(0, 29) == 0);
      b_seed      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b_taps_load = ($urandom_range(0, 29) == 0);
      b_taps      = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      b_enable    = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++; if ({a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== exp_a()) begin n_fail++; $display("FAIL random_a%0d: got %b want %b", i, {a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}, exp_a()); end
      n_checks++; if ({b_state, b_data, b_data_valid, b_wrapped, b_cfg_err, b_q} !== exp_b()) begin n_fail++; $display("FAIL random_b%0d: got %h want %h", i, {b_state, b_data, b_data_valid, b_wrapped, b_cfg_err, b_q}, exp_b()); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    a_seed = 4'b0001; a_taps = 4'b1100; a_load = 1'b1; a_taps_load = 1'b1;
    b_seed = 32'hDEAD_BEEF; b_load = 1'b1;
    tick();
    a_load = 1'b0; a_taps_load = 1'b0; b_load = 1'b0;
    a_enable = 1'b1; a_out_ready = 1'b0; b_enable = 1'b1;
    repeat (5) tick();
    n_checks++; if (a_data_valid !== 1'b1 || a_state !== 4'b0011) begin n_fail++; $display("FAIL areset_setup: valid %b state %b want 1 0011", a_data_valid, a_state); end
    #4;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if ({a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== 12'b0001_0000_0000) begin n_fail++; $display("FAIL areset_a_now: got %b want 000100000000", {a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}); end
    n_checks++; if (b_state !== 32'h1 || b_data_valid !== 1'b0 || b_data !== 8'h0) begin n_fail++; $display("FAIL areset_b_now: state %h valid %b data %h want 00000001 0 00", b_state, b_data_valid, b_data); end
    idle_inputs();
    #9;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({a_wrapped, a_cfg_err, b_wrapped, b_cfg_err, a_data_valid, b_data_valid} !== 6'b0) begin n_fail++; $display("FAIL areset_no_pulse%0d: got %b want 000000", i, {a_wrapped, a_cfg_err, b_wrapped, b_cfg_err, a_data_valid, b_data_valid}); end
      n_checks++; if ({a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q} !== exp_a()) begin n_fail++; $display("FAIL areset_model%0d: got %b want %b", i, {a_state, a_data, a_data_valid, a_wrapped, a_cfg_err, a_q}, exp_a()); end
    end
  endtask

  initial begin
    test_reset();
    test_seq4();
    test_stall();
    test_zero_guard();
    test_defaults();
    test_cfg_err();
    test_load_midword();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
